pe_net_interface: RTL
=====================

// Module: pe_net_interface
// PURPOSE
//  Network interface between one processing element (PE) and one leaf port of the H-tree switch fabric (switch2 ports 1/2).
//  TX path: packs PE payload plus destination address into one flit, buffers it and presents it to the switch.
//  RX path: accepts flits from the switch, checks the destination address, strips the header and buffers the payload for the PE.
//  Counts misrouted flits for debug.
// PARAMETERS
//  DataWidth  32  flit width on the switch side
//  AddrWidth  4   destination field width, flit bits [DataWidth-1 -: AddrWidth] (16 PEs)
//  MyAddr     0   this PE's address, compared against RX flit headers
//  FifoDepth  4   entries per direction; power of 2, >=2
// PORTS
//  i_sclk            in   1                    single clock, rising edge
//  i_reset           in   1                    reset, asynchronous, active-low
//  i_pe_data         in   DataWidth-AddrWidth  TX payload from PE
//  i_pe_dest         in   AddrWidth            TX destination address
//  i_pe_valid        in   1                    TX payload valid
//  o_pe_ready        out  1                    interface can accept TX payload
//  o_net_data        out  DataWidth            flit to switch
//  o_net_valid       out  1                    flit valid
//  i_net_ready       in   1                    switch accepts flit
//  i_net_data        in   DataWidth            flit from switch
//  i_net_valid       in   1                    flit valid
//  o_net_ready       out  1                    interface can accept flit
//  o_pe_data         out  DataWidth-AddrWidth  RX payload to PE
//  o_pe_valid        out  1                    RX payload valid
//  i_pe_ready        in   1                    PE accepts RX payload
//  o_misroute_count  out  8                    flits received with header != MyAddr, saturating
// BEHAVIOUR
//  - Transfer happens on a rising edge where valid && ready. Valid never depends combinationally on ready, and ready never on valid.
//  - Reset (i_reset=0):
//    - FIFO pointers/counts, misroute counter and run flag are cleared.
//    - o_net_valid, o_pe_valid, o_pe_ready, o_net_ready = 0; data outputs = 0.
//    - Queued flits are discarded when reset is asserted mid-operation.
//  - Run flag: RESET -> RUN on the first i_sclk edge with i_reset=1. Both readies are gated by RUN, so the earliest readies come one cycle after reset release.
//  - TX FIFO:
//    - o_pe_ready = RUN && !tx_full.
//    - A PE transfer writes {i_pe_dest, i_pe_data}.
//    - o_net_valid = !tx_empty; o_net_data = head entry (first-word-fall-through from registers).
//    - Latency: a PE transfer at edge N into an empty FIFO gives o_net_valid=1 in the cycle after edge N.
//    - o_net_data holds stable while o_net_valid && !i_net_ready.
//    - Simultaneous write+read in one edge: count unchanged, both pointers advance; legal at any non-full occupancy.
//    - Full (count==FifoDepth): o_pe_ready=0.
//    - Pointers wrap modulo FifoDepth.
//  - RX path:
//    - o_net_ready = RUN && !rx_full. The ready is common to all flits, so a full RX FIFO also stalls misrouted flits.
//    - On a net transfer with header==MyAddr, write payload = i_net_data[DataWidth-AddrWidth-1:0].
//    - On a net transfer with header!=MyAddr, drop the flit (no FIFO write) and increment o_misroute_count, saturating at 255.
//    - o_pe_valid = !rx_empty; o_pe_data = head payload. Same fall-through, stability, simultaneous and wrap rules as TX.
//  - TX and RX are independent; a PE sending to MyAddr is not short-circuited (the flit traverses the fabric).
// TESTING
//  - Reset: drive i_reset=0 with traffic active -> all valids/readies 0 and count 0. Release reset -> readies 1 one edge later.
//  - TX single: dest=4'h5, data=28'h0ABCDEF, no backpressure -> o_net_data=32'h50ABCDEF, valid the cycle after the accept, held until i_net_ready.
//  - TX full: i_net_ready=0, push 5 payloads at depth 4 -> o_pe_ready=0 after the 4th. Raise ready -> 4 flits out in order, 5th accepted after the first pop.
//  - RX match/mismatch: MyAddr=3, send 32'h3000_0011 then 32'h7000_0022 -> o_pe_data=28'h0000011 only, misroute_count=1.
//  - Saturation: 300 misrouted flits -> o_misroute_count=255, RX FIFO empty.
//  - Concurrent: full-rate TX and RX with random ready stalls for 1000 flits -> no loss, no duplication, in-order per direction.

Source files
------------

// File: rtl/pe_net_interface.sv
// ---------------------------------------------------------------------------
// pe_net_interface
//   Network interface between one processing element and one leaf port of
//   the H-tree switch fabric.
//   TX: PE payload + destination are packed into one flit
//       {dest, payload}, queued, and presented to the switch.
//   RX: flits whose header matches MyAddr have the header stripped and the
//       payload queued for the PE. Flits addressed elsewhere are dropped
//       and counted in a saturating misroute counter.
//   Both queues are register FIFOs with first-word-fall-through heads.
//
// Ports
//   i_sclk, i_reset           clock (rising edge), async active-low reset
//   i_pe_data/dest/valid      TX payload + destination from PE
//   o_pe_ready                TX path can accept a payload
//   o_net_data/valid          flit to switch
//   i_net_ready               switch accepts flit
//   i_net_data/valid          flit from switch
//   o_net_ready               RX path can accept a flit (matched or not)
//   o_pe_data/valid           RX payload to PE
//   i_pe_ready                PE accepts RX payload
//   o_misroute_count          flits seen with header != MyAddr, saturates
// ---------------------------------------------------------------------------

// Register FIFO with fall-through head. Callers guarantee wrEn only when
// !full and rdEn only when !empty.
module pe_net_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         wrEn,
  input  logic [W-1:0] wrData,
  input  logic         rdEn,
  output logic [W-1:0] rdData,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wrPtr, rdPtr;
  logic [CW-1:0]           cnt;

  // Storage is cleared on reset so the data outputs read 0 while in reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (wrEn) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;   // power-of-2 depth: natural wrap
      end
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;          // idle, or push+pop together
      endcase
    end
  end

  assign rdData = mem[rdPtr];
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
endmodule

module pe_net_interface #(
  parameter int          DataWidth = 32,
  parameter int          AddrWidth = 4,
  parameter int unsigned MyAddr    = 0,
  parameter int          FifoDepth = 4
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
  input  logic [AddrWidth-1:0]           i_pe_dest,
  input  logic                           i_pe_valid,
  output logic                           o_pe_ready,
  output logic [DataWidth-1:0]           o_net_data,
  output logic                           o_net_valid,
  input  logic                           i_net_ready,
  input  logic [DataWidth-1:0]           i_net_data,
  input  logic                           i_net_valid,
  output logic                           o_net_ready,
  output logic [DataWidth-AddrWidth-1:0] o_pe_data,
  output logic                           o_pe_valid,
  input  logic                           i_pe_ready,
  output logic [7:0]                     o_misroute_count
);
  localparam int PayW = DataWidth - AddrWidth;
  localparam logic [AddrWidth-1:0] MyAddrL = AddrWidth'(MyAddr);

  // Run flag: readies stay low for the first edge after reset release so
  // nothing is accepted on the same edge reset deasserts.
  logic run;
  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) run <= 1'b0;
    else          run <= 1'b1;
  end

  // ---------------- TX path ----------------
  logic txFull, txEmpty, txWr, txRd;

  assign o_pe_ready  = run & ~txFull;
  assign o_net_valid = ~txEmpty;
  assign txWr        = i_pe_valid & o_pe_ready;
  assign txRd        = o_net_valid & i_net_ready;

  pe_net_fifo #(.W(DataWidth), .DEPTH(FifoDepth)) uTxFifo (
    .clk    (i_sclk),
    .rstN   (i_reset),
    .wrEn   (txWr),
    .wrData ({i_pe_dest, i_pe_data}),
    .rdEn   (txRd),
    .rdData (o_net_data),
    .full   (txFull),
    .empty  (txEmpty)
  );

  // ---------------- RX path ----------------
  // One ready for every flit: a full RX queue also stalls misrouted flits,
  // so the misroute count never races ahead of accepted traffic.
  logic rxFull, rxEmpty, netXfer, hdrMatch, rxWr, rxRd;

  assign o_net_ready = run & ~rxFull;
  assign o_pe_valid  = ~rxEmpty;
  assign netXfer     = i_net_valid & o_net_ready;
  assign hdrMatch    = (i_net_data[DataWidth-1 -: AddrWidth] == MyAddrL);
  assign rxWr        = netXfer & hdrMatch;
  assign rxRd        = o_pe_valid & i_pe_ready;

  pe_net_fifo #(.W(PayW), .DEPTH(FifoDepth)) uRxFifo (
    .clk    (i_sclk),
    .rstN   (i_reset),
    .wrEn   (rxWr),
    .wrData (i_net_data[PayW-1:0]),
    .rdEn   (rxRd),
    .rdData (o_pe_data),
    .full   (rxFull),
    .empty  (rxEmpty)
  );

  // Misroute counter, saturating at 255.
  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset)
      o_misroute_count <= '0;
    else if (netXfer && !hdrMatch && (o_misroute_count != 8'hFF))
      o_misroute_count <= o_misroute_count + 1'b1;
  end
endmodule
